// File: rtl/ghost_ctrl_pkg.sv
// Shared types, register map and geometry helpers for the ghost motion sequencer.
package ghost_ctrl_pkg;

  localparam int unsigned POS_W = 11;
  localparam int unsigned BNC_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01
  } state_t;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_UP    = 2'b11
  } dir_t;

  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_START_X = 3'd1;
  localparam logic [2:0] REG_START_Y = 3'd2;
  localparam logic [2:0] REG_SPEED   = 3'd3;
  localparam logic [2:0] REG_STATUS  = 3'd4;

  // STATUS read word layout
  typedef struct packed {
    logic [BNC_W-1:0] bounce;
    state_t           state;
    dir_t             dir;
    logic [POS_W-1:0] y0;
    logic [POS_W-1:0] x0;
  } status_t;

  // Largest origin that keeps the sprite fully on screen
  function automatic logic [POS_W-1:0] calc_max(input int unsigned res, input int unsigned spr);
    return POS_W'(res - spr);
  endfunction

endpackage

// File: rtl/ghost_axis_step.sv
// One axis of the per-frame step: load/clamp, advance, bounce at the edges.
module ghost_axis_step
  import ghost_ctrl_pkg::*;
#(
  parameter int unsigned SPD_W = 4
) (
  input  logic [POS_W-1:0] pos,
  input  logic             dir,
  input  logic [SPD_W-1:0] speed,
  input  logic [POS_W-1:0] max_pos,
  input  logic             tick,
  input  logic             run,
  input  logic             load,
  input  logic [POS_W-1:0] start,
  output logic [POS_W-1:0] pos_c,
  output logic             dir_c,
  output logic             flip_c
);

  localparam int unsigned AW = POS_W + 1;

  logic [AW-1:0] pos_w;
  logic [AW-1:0] spd_w;
  logic [AW-1:0] sum_w;

  assign pos_w = AW'(pos);
  assign spd_w = AW'(speed);
  assign sum_w = pos_w + spd_w;

  // dir: 0 = increasing coordinate, 1 = decreasing
  always_comb begin
    pos_c  = pos;
    dir_c  = dir;
    flip_c = 1'b0;
    if (tick && load) begin
      pos_c = (start > max_pos) ? max_pos : start;
      dir_c = 1'b0;
    end else if (tick && run && (speed != '0)) begin
      if (!dir) begin
        if (sum_w >= AW'(max_pos)) begin
          pos_c  = max_pos;
          dir_c  = 1'b1;
          flip_c = 1'b1;
        end else begin
          pos_c = POS_W'(sum_w);
        end
      end else begin
        if (pos_w <= spd_w) begin
          pos_c  = '0;
          dir_c  = 1'b0;
          flip_c = 1'b1;
        end else begin
          pos_c = POS_W'(pos_w - spd_w);
        end
      end
    end
  end

endmodule

// File: rtl/ghost_motion_ctrl.sv
// Ghost sprite sequencer: CPU register slot, per-frame motion with edge bounce,
// and the origin/ctrl drive for the ghost sprite core.
module ghost_motion_ctrl
  import ghost_ctrl_pkg::*;
#(
  parameter int unsigned H_RES    = 640,
  parameter int unsigned V_RES    = 480,
  parameter int unsigned SPR_SIZE = 16,
  parameter int unsigned SPD_W    = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [POS_W-1:0]    x,
  input  logic [POS_W-1:0]    y,
  input  logic                cs,
  input  logic                write,
  input  logic                read,
  input  logic [2:0]          addr,
  input  logic [31:0]         wr_data,
  output logic [31:0]         rd_data,
  output logic [POS_W-1:0]    x0,
  output logic [POS_W-1:0]    y0,
  output logic [4:0]          ctrl
);

  localparam logic [POS_W-1:0] XMAX = calc_max(H_RES, SPR_SIZE);
  localparam logic [POS_W-1:0] YMAX = calc_max(V_RES, SPR_SIZE);
  localparam logic [BNC_W-1:0] BNC_SAT = '1;

  logic             run_q;
  logic             auto_q;
  logic [1:0]       colour_q;
  logic [POS_W-1:0] start_x_q;
  logic [POS_W-1:0] start_y_q;
  logic [SPD_W-1:0] dx_q;
  logic [SPD_W-1:0] dy_q;
  logic [POS_W-1:0] x_d1;
  logic             xdir_q;
  logic             ydir_q;
  logic [BNC_W-1:0] bounce_q;
  logic [BNC_W-1:0] bounce_d;
  logic             load_pending_q;
  logic             load_pending_d;
  state_t           state_q;
  state_t           state_d;

  logic             wr_en;
  logic             tick;
  logic             running;
  logic [POS_W-1:0] x_pos_c;
  logic [POS_W-1:0] y_pos_c;
  logic             xdir_c;
  logic             ydir_c;
  logic             xflip_c;
  logic             yflip_c;
  dir_t             dir;
  logic [4:0]       ctrl_nxt;
  status_t          status;
  logic             unused_bits;

  assign wr_en   = cs && write;
  assign tick    = (x_d1 == '0) && (x == POS_W'(1)) && (y == '0);
  assign running = (state_q == RUN);
  assign unused_bits = ^{read, wr_data[31:POS_W]};

  ghost_axis_step #(.SPD_W(SPD_W)) u_x_axis (
    .pos(x0), .dir(xdir_q), .speed(dx_q), .max_pos(XMAX), .tick(tick), .run(running),
    .load(load_pending_q), .start(start_x_q), .pos_c(x_pos_c), .dir_c(xdir_c), .flip_c(xflip_c)
  );

  ghost_axis_step #(.SPD_W(SPD_W)) u_y_axis (
    .pos(y0), .dir(ydir_q), .speed(dy_q), .max_pos(YMAX), .tick(tick), .run(running),
    .load(load_pending_q), .start(start_y_q), .pos_c(y_pos_c), .dir_c(ydir_c), .flip_c(yflip_c)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (run_q)  state_d = RUN;
      RUN:     if (!run_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A write on the tick cycle wins, so that load is served on the following tick
  always_comb begin
    load_pending_d = load_pending_q;
    if (wr_en && ((addr == REG_START_X) || (addr == REG_START_Y)))
      load_pending_d = 1'b1;
    else if (tick)
      load_pending_d = 1'b0;

    bounce_d = bounce_q;
    if (tick && load_pending_q)
      bounce_d = '0;
    else if ((xflip_c || yflip_c) && (bounce_q != BNC_SAT))
      bounce_d = bounce_q + BNC_W'(1);
  end

  always_comb begin
    if (dx_q >= dy_q) dir = xdir_q ? DIR_LEFT : DIR_RIGHT;
    else              dir = ydir_q ? DIR_UP : DIR_DOWN;
    ctrl_nxt = {colour_q, auto_q, auto_q ? 2'b00 : dir};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q          <= 1'b0;
      auto_q         <= 1'b0;
      colour_q       <= '0;
      start_x_q      <= '0;
      start_y_q      <= '0;
      dx_q           <= '0;
      dy_q           <= '0;
      x_d1           <= '0;
      x0             <= '0;
      y0             <= '0;
      xdir_q         <= 1'b0;
      ydir_q         <= 1'b0;
      bounce_q       <= '0;
      load_pending_q <= 1'b0;
      ctrl           <= '0;
    end else begin
      x_d1           <= x;
      x0             <= x_pos_c;
      y0             <= y_pos_c;
      xdir_q         <= xdir_c;
      ydir_q         <= ydir_c;
      bounce_q       <= bounce_d;
      load_pending_q <= load_pending_d;
      ctrl           <= ctrl_nxt;
      if (wr_en) begin
        case (addr)
          REG_CTRL: begin
            run_q    <= wr_data[0];
            auto_q   <= wr_data[1];
            colour_q <= wr_data[3:2];
          end
          REG_START_X: start_x_q <= wr_data[POS_W-1:0];
          REG_START_Y: start_y_q <= wr_data[POS_W-1:0];
          REG_SPEED: begin
            dx_q <= wr_data[SPD_W-1:0];
            dy_q <= wr_data[2*SPD_W-1:SPD_W];
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    status.bounce = bounce_q;
    status.state  = state_q;
    status.dir    = dir;
    status.y0     = y0;
    status.x0     = x0;
    rd_data = '0;
    case (addr)
      REG_CTRL:    rd_data = 32'({colour_q, auto_q, run_q});
      REG_START_X: rd_data = 32'(start_x_q);
      REG_START_Y: rd_data = 32'(start_y_q);
      REG_SPEED:   rd_data = 32'({dy_q, dx_q});
      REG_STATUS:  rd_data = status;
      default:     rd_data = '0;
    endcase
  end

endmodule
